// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA streamer and its burst calculator.
package dma_pkg;

  localparam int unsigned DMA_BEAT_BYTES = 64;
  localparam int unsigned DMA_4K_BYTES   = 4096;

  // Request toward the AXI interface block; one 64-byte data lane.
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  alen;
    logic [2:0]  size;
    logic [63:0] strb;
    logic        valid;
  } s_dma_axi_req_t;

  typedef struct packed {
    logic ready;
  } s_dma_axi_resp_t;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StReq,
    StDone
  } e_streamer_state_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Combinational next-request calculator: burst length, beat size and byte strobe
// for the current address and remaining byte count.
// DMA_STREAMER_4K_SPLIT_EN: when defined, full bursts never cross a 4 KiB page.
module dma_burst_calc import dma_pkg::*; #(
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic [31:0] addr_i,
  input  logic [31:0] rem_i,
  output logic [7:0]  alen_o,
  output logic [2:0]  size_o,
  output logic [63:0] strb_o
);

  logic        full;
  logic [31:0] beats;
  logic [63:0] mask;

  // Pick full-width burst when aligned with at least one beat left, else one narrow beat.
  always_comb begin
    full   = (addr_i[5:0] == 6'd0) && (rem_i >= DMA_BEAT_BYTES);
    beats  = rem_i >> 6;
    if (beats > MAX_BEATS) beats = MAX_BEATS;
`ifdef DMA_STREAMER_4K_SPLIT_EN
    begin
      logic [31:0] page_beats;
      page_beats = (DMA_4K_BYTES - {20'd0, addr_i[11:0]}) >> 6;
      if (beats > page_beats) beats = page_beats;
    end
`endif
    alen_o = 8'd0;
    size_o = 3'd0;
    strb_o = '0;
    mask   = '0;
    if (full) begin
      alen_o = 8'(beats - 32'd1);
      size_o = 3'd6;
      strb_o = '1;
    end else begin
      // Ascending scan leaves the largest size that fits both length and alignment.
      for (int n = 0; n <= 6; n++) begin
        if (((32'd1 << n) <= rem_i) && ((addr_i & ((32'd1 << n) - 32'd1)) == 32'd0)) begin
          size_o = 3'(n);
        end
      end
      mask   = (size_o == 3'd6) ? '1 : ((64'd1 << (7'd1 << size_o)) - 64'd1);
      strb_o = mask << addr_i[5:0];
    end
  end

endmodule

// File: rtl/dma_streamer.sv
// Splits a (start address, byte count) descriptor into a sequence of AXI
// requests, one outstanding at a time.
// DMA_STREAMER_4K_SPLIT_EN: when defined, full bursts are cut at 4 KiB pages.
module dma_streamer import dma_pkg::*; #(
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [31:0]     desc_addr_i,
  input  logic [31:0]     desc_bytes_i,
  input  logic            dma_go_i,
  input  logic            dma_active_i,
  input  logic            clear_dma_i,
  output s_dma_axi_req_t  dma_axi_req_o,
  input  s_dma_axi_resp_t dma_axi_resp_i,
  output logic            stream_done_o
);

  e_streamer_state_t state_q, state_d;
  logic [31:0] addr_q, addr_d;   // current stream address A
  logic [31:0] rem_q, rem_d;     // remaining bytes R
  logic [31:0] req_addr_q, req_addr_d;
  logic [7:0]  req_alen_q, req_alen_d;
  logic [2:0]  req_size_q, req_size_d;
  logic [63:0] req_strb_q, req_strb_d;

  logic [7:0]  calc_alen;
  logic [2:0]  calc_size;
  logic [63:0] calc_strb;
  logic [31:0] xfer_bytes;

  dma_burst_calc #(
    .MAX_BEATS (MAX_BEATS)
  ) u_burst_calc (
    .addr_i (addr_q),
    .rem_i  (rem_q),
    .alen_o (calc_alen),
    .size_o (calc_size),
    .strb_o (calc_strb)
  );

  assign xfer_bytes = ({24'd0, req_alen_q} + 32'd1) << req_size_q;

  // Next-state, counter and request-payload logic; abort has top priority.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    req_addr_d = req_addr_q;
    req_alen_d = req_alen_q;
    req_size_d = req_size_q;
    req_strb_d = req_strb_q;
    if (!dma_active_i) begin
      state_d    = StIdle;
      addr_d     = '0;
      rem_d      = '0;
      req_addr_d = '0;
      req_alen_d = '0;
      req_size_d = '0;
      req_strb_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dma_go_i) begin
            addr_d  = desc_addr_i;
            rem_d   = desc_bytes_i;
            state_d = (desc_bytes_i == 32'd0) ? StDone : StCalc;
          end
        end
        StCalc: begin
          req_addr_d = addr_q;
          req_alen_d = calc_alen;
          req_size_d = calc_size;
          req_strb_d = calc_strb;
          state_d    = StReq;
        end
        StReq: begin
          if (dma_axi_resp_i.ready) begin
            addr_d  = addr_q + xfer_bytes;
            rem_d   = rem_q - xfer_bytes;
            state_d = (rem_d == 32'd0) ? StDone : StCalc;
          end
        end
        StDone: begin
          if (clear_dma_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, counters and request payload registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rem_q      <= '0;
      req_addr_q <= '0;
      req_alen_q <= '0;
      req_size_q <= '0;
      req_strb_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      req_addr_q <= req_addr_d;
      req_alen_q <= req_alen_d;
      req_size_q <= req_size_d;
      req_strb_q <= req_strb_d;
    end
  end

  // Valid decodes straight from the state flop so reset drops it at once.
  always_comb begin
    dma_axi_req_o.addr  = req_addr_q;
    dma_axi_req_o.alen  = req_alen_q;
    dma_axi_req_o.size  = req_size_q;
    dma_axi_req_o.strb  = req_strb_q;
    dma_axi_req_o.valid = (state_q == StReq);
    stream_done_o       = (state_q == StDone);
  end

endmodule

// File: tb/tb_dma_streamer.sv
// Directed self-checking bench for dma_streamer.
module tb_dma_streamer;
  import dma_pkg::*;

  logic            clk;
  logic            rstn;
  logic [31:0]     desc_addr;
  logic [31:0]     desc_bytes;
  logic            dma_go;
  logic            dma_active;
  logic            clear_dma;
  s_dma_axi_req_t  req;
  s_dma_axi_resp_t resp;
  logic            done;

  int errors = 0;
  int checks = 0;

  dma_streamer #(
    .MAX_BEATS (256)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .desc_addr_i    (desc_addr),
    .desc_bytes_i   (desc_bytes),
    .dma_go_i       (dma_go),
    .dma_active_i   (dma_active),
    .clear_dma_i    (clear_dma),
    .dma_axi_req_o  (req),
    .dma_axi_resp_i (resp),
    .stream_done_o  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    desc_addr  = a;
    desc_bytes = b;
    dma_go     = 1'b1;
    @(negedge clk);
    dma_go     = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!req.valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 128'(req.valid), 128'd1);
  endtask

  // Waits for a request, checks its payload, then lets it handshake (ready high).
  task automatic expect_req(input string tag, input logic [31:0] a, input logic [7:0] l,
                            input logic [2:0] s, input logic [63:0] st);
    wait_valid(tag, 20);
    check({tag, "_addr"}, 128'(req.addr), 128'(a));
    check({tag, "_alen"}, 128'(req.alen), 128'(l));
    check({tag, "_size"}, 128'(req.size), 128'(s));
    check({tag, "_strb"}, 128'(req.strb), 128'(st));
    @(negedge clk);
  endtask

  task automatic clear_done(input string tag);
    clear_dma = 1'b1;
    @(negedge clk);
    clear_dma = 1'b0;
    check({tag, "_cleared"}, 128'({done, req.valid}), 128'd0);
  endtask

  initial begin
    rstn       = 1'b0;
    desc_addr  = '0;
    desc_bytes = '0;
    dma_go     = 1'b0;
    dma_active = 1'b1;
    clear_dma  = 1'b0;
    resp.ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 128'(req.valid), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_payload", 128'({req.addr, req.alen, req.size, req.strb}), 128'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Aligned 16 KiB stream.
    start(32'h1000, 32'h4000);
`ifdef DMA_STREAMER_4K_SPLIT_EN
    expect_req("big0", 32'h1000, 8'd63, 3'd6, '1);
    expect_req("big1", 32'h2000, 8'd63, 3'd6, '1);
    expect_req("big2", 32'h3000, 8'd63, 3'd6, '1);
    expect_req("big3", 32'h4000, 8'd63, 3'd6, '1);
`else
    expect_req("big", 32'h1000, 8'd255, 3'd6, '1);
`endif
    check("big_done", 128'({done, req.valid}), 128'b10);
    clear_done("big");

    // Stream straddling a 4 KiB boundary.
    start(32'h0FC0, 32'h100);
`ifdef DMA_STREAMER_4K_SPLIT_EN
    expect_req("pg0", 32'h0FC0, 8'd0, 3'd6, '1);
    check("pg_calc_gap", 128'(req.valid), 128'd0);
    expect_req("pg1", 32'h1000, 8'd2, 3'd6, '1);
`else
    expect_req("pg", 32'h0FC0, 8'd3, 3'd6, '1);
`endif
    check("pg_done", 128'(done), 128'd1);
    clear_done("pg");

    // Unaligned short stream: byte then word.
    start(32'h3, 32'd5);
    expect_req("nar0", 32'h3, 8'd0, 3'd0, 64'h8);
    check("nar_calc_gap", 128'(req.valid), 128'd0);
    expect_req("nar1", 32'h4, 8'd0, 3'd2, 64'hF0);
    check("nar_done", 128'(done), 128'd1);
    clear_done("nar");

    // Back-pressure: ready low for 10 cycles.
    resp.ready = 1'b0;
    start(32'h40, 32'h80);
    wait_valid("stall", 20);
    for (int i = 0; i < 10; i++) begin
      check("stall_hold", 128'({req.valid, done, req.addr, req.alen, req.size, req.strb}),
            {19'd0, 1'b1, 1'b0, 32'h40, 8'd1, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF});
      @(negedge clk);
    end
    resp.ready = 1'b1;
    @(negedge clk);
    check("stall_done", 128'({done, req.valid}), 128'b10);
    clear_done("stall");

    // Zero-length stream; go in DONE is ignored.
    start(32'h100, 32'd0);
    check("zero_done", 128'({done, req.valid}), 128'b10);
    start(32'h200, 32'h40);
    @(negedge clk);
    check("zero_go_ignored", 128'({done, req.valid}), 128'b10);
    clear_done("zero");
    repeat (3) @(negedge clk);
    check("zero_idle", 128'({done, req.valid}), 128'd0);

    // Abort mid-REQ via dma_active_i.
    resp.ready = 1'b0;
    start(32'h0, 32'h1000);
    wait_valid("abort", 20);
    dma_active = 1'b0;
    @(negedge clk);
    check("abort_valid", 128'({done, req.valid}), 128'd0);
    check("abort_payload", 128'({req.addr, req.alen, req.strb}), 128'd0);
    dma_active = 1'b1;
    resp.ready = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle", 128'({done, req.valid}), 128'd0);

    // Asynchronous reset mid-REQ.
    resp.ready = 1'b0;
    start(32'h0, 32'h80);
    wait_valid("rstreq", 20);
    #2 rstn = 1'b0;
    #1 check("rstreq_valid", 128'(req.valid), 128'd0);
    @(negedge clk);
    rstn       = 1'b1;
    resp.ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rstreq_idle", 128'({done, req.valid}), 128'd0);

    // Asynchronous reset mid-CALC, then a fresh stream must start clean.
    start(32'h0, 32'h80);
    #2 rstn = 1'b0;
    #1 check("rstcalc_payload", 128'({req.valid, req.addr, req.alen}), 128'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("rstcalc_idle", 128'({done, req.valid}), 128'd0);
    start(32'h80, 32'h40);
    expect_req("fresh", 32'h80, 8'd0, 3'd6, '1);
    check("fresh_done", 128'(done), 128'd1);
    clear_done("fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
